valid_array_mp: RTL

//  Parametrised multi-entry, multi-ported valid/busy bit array. Generalises the single-entry 4W/4R

---
 rtl/valid_array_pkg.sv | 18 +
 rtl/valid_prio_enc.sv | 23 ++
 rtl/valid_array_mp.sv | 83 ++++++++
 3 files changed

// File: rtl/valid_array_pkg.sv
// Shared sizing helpers for valid/busy bit arrays (ROB, issue queue, free list).
package valid_array_pkg;

    // Index width for an array of n entries; at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold every count 0..n without wrapping.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Default depth used by the 2-wide core bookkeeping arrays.
    localparam int DEF_ENTRIES = 16;
    typedef logic [DEF_ENTRIES-1:0] def_vec_t;

endpackage

// File: rtl/valid_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest 1 in vec, or 0 with vld=0 if vec is empty.
module valid_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so the lowest set bit is the last one to assign.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/valid_array_mp.sv
// Multi-entry, multi-ported valid/busy bit array with flush, popcount and lowest-set-entry status.
module valid_array_mp
    import valid_array_pkg::*;
#(
    parameter int   NUM_ENTRIES = 16,
    parameter int   NUM_WR      = 4,
    parameter int   NUM_RD      = 4,
    parameter logic RESET_VAL   = 1'b1,
    parameter int   IDX_W       = idx_w(NUM_ENTRIES),
    parameter int   CNT_W       = cnt_w(NUM_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR-1:0][IDX_W-1:0] wr_idx_i,
    input  logic [NUM_WR-1:0]            wr_data_i,
    input  logic [NUM_RD-1:0]            rd_en_i,
    input  logic [NUM_RD-1:0][IDX_W-1:0] rd_idx_i,
    output logic [NUM_RD-1:0]            rd_data_o,
    output logic [NUM_ENTRIES-1:0]       valid_vec_o,
    output logic [CNT_W-1:0]             set_cnt_o,
    output logic [IDX_W-1:0]             first_idx_o,
    output logic                         first_vld_o
);

    logic [NUM_ENTRIES-1:0] state;
    logic [NUM_ENTRIES-1:0] state_nxt;

    // Per-entry write select: walk ports high to low so the lowest-numbered matching port wins.
    // Out-of-range indices never match any entry, and a disabled port never matches even with X idx.
    always_comb begin
        state_nxt = state;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            for (int p = NUM_WR - 1; p >= 0; p--) begin
                if (wr_en_i[p] && (int'(wr_idx_i[p]) == e)) begin
                    state_nxt[e] = wr_data_i[p];
                end
            end
        end
    end

    // State register: reset beats flush, flush discards every write of its cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= {NUM_ENTRIES{RESET_VAL}};
        end else if (flush_i) begin
            state <= {NUM_ENTRIES{RESET_VAL}};
        end else begin
            state <= state_nxt;
        end
    end

    // Reads see current state only (no bypass); disabled or out-of-range ports return 0.
    always_comb begin
        rd_data_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (rd_en_i[r] && (int'(rd_idx_i[r]) < NUM_ENTRIES)) begin
                rd_data_o[r] = state[rd_idx_i[r]];
            end
        end
    end

    // Exact popcount of the current state.
    always_comb begin
        set_cnt_o = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            set_cnt_o = set_cnt_o + CNT_W'(state[e]);
        end
    end

    assign valid_vec_o = state;

    valid_prio_enc #(
        .N     (NUM_ENTRIES),
        .IDX_W (IDX_W)
    ) u_first (
        .vec (state),
        .idx (first_idx_o),
        .vld (first_vld_o)
    );

endmodule
